// File: rtl/uart_tx_stream.sv
// Buffer-fed UART transmitter: streams tx_len bytes from a synchronous-read buffer as contiguous 8N1 frames.
// Define UART_TX_STREAM_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH_LOG2   = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_start,
  input  logic [DEPTH_LOG2:0]   tx_len,
  input  logic                  tx_abort,
  output logic [DEPTH_LOG2-1:0] tx_buf_ra,
  output logic                  tx_buf_ren,
  input  logic [7:0]            tx_buf_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_STREAM_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [DEPTH_LOG2:0] L_MAX_LEN    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [15:0]         L_BIT_LAST   = 16'(CLKS_PER_BIT - 1);
  // Two cycles before the end of the stop bit; unreachable (16'hFFFF) when CLKS_PER_BIT is 2.
  localparam logic [15:0]         L_STOP_FETCH = 16'(CLKS_PER_BIT - 3);
  localparam logic                L_SHORT_BIT  = (CLKS_PER_BIT == 2);

  state_t                r_state;
  logic [15:0]           r_baud;
  logic [2:0]            r_bit;
  logic [7:0]            r_shift;
  logic [DEPTH_LOG2:0]   r_left;
  logic [DEPTH_LOG2-1:0] r_ra;
  logic                  r_ren;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  logic [DEPTH_LOG2:0]   w_len;
  logic                  w_bit_end;
  logic                  w_more;
  logic                  w_payload_end;
  logic                  w_next_fetch;

  assign w_len     = (tx_len > L_MAX_LEN) ? L_MAX_LEN : tx_len;
  assign w_bit_end = (r_baud == L_BIT_LAST);
  assign w_more    = (r_left != '0);

`ifdef UART_TX_STREAM_PARITY_EN
  assign w_payload_end = w_bit_end && (r_state == S_PARITY);
`else
  assign w_payload_end = w_bit_end && (r_state == S_DATA) && (r_bit == 3'd7);
`endif

  // The last two stop-bit cycles double as FETCH/LOAD of the next byte; with a
  // two-cycle bit the whole stop bit is spent that way.
  assign w_next_fetch = w_more &&
                        ((w_payload_end && L_SHORT_BIT) ||
                         ((r_state == S_STOP) && (r_baud == L_STOP_FETCH)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_left  <= '0;
      r_ra    <= '0;
      r_ren   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; these pulse defaults are overridden by any later assignment this edge.
      r_done <= 1'b0;
      r_ren  <= 1'b0;
      if (tx_abort) begin
        r_state <= S_IDLE;
        r_baud  <= '0;
        r_bit   <= '0;
        r_left  <= '0;
        r_ra    <= '0;
        r_tx    <= 1'b1;
        r_busy  <= 1'b0;
      end else if (w_next_fetch) begin
        r_state <= S_FETCH;
        r_ren   <= 1'b1;
        r_ra    <= r_ra + 1'b1;
        r_left  <= r_left - 1'b1;
        r_baud  <= '0;
        r_tx    <= 1'b1;
      end else if (w_payload_end) begin
        r_state <= S_STOP;
        r_baud  <= '0;
        r_tx    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (tx_start) begin
              if (w_len == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_FETCH;
                r_ren   <= 1'b1;
                r_ra    <= '0;
                r_left  <= w_len - 1'b1;
                r_busy  <= 1'b1;
              end
            end
          end
          S_FETCH: r_state <= S_LOAD;
          S_LOAD: begin
            r_shift <= tx_buf_rd;
            r_state <= S_START;
            r_baud  <= '0;
            r_tx    <= 1'b0;
          end
          S_START: begin
            if (w_bit_end) begin
              r_state <= S_DATA;
              r_baud  <= '0;
              r_bit   <= '0;
              r_tx    <= r_shift[0];
            end else begin
              r_baud <= r_baud + 16'd1;
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_baud <= '0;
`ifdef UART_TX_STREAM_PARITY_EN
              if (r_bit == 3'd7) begin
                r_state <= S_PARITY;
                r_tx    <= ^r_shift;
              end else
`endif
              begin
                r_bit <= r_bit + 3'd1;
                r_tx  <= r_shift[r_bit + 3'd1];
              end
            end else begin
              r_baud <= r_baud + 16'd1;
            end
          end
`ifdef UART_TX_STREAM_PARITY_EN
          S_PARITY: r_baud <= r_baud + 16'd1;
`endif
          S_STOP: begin
            if (w_bit_end) begin
              r_state <= S_IDLE;
              r_baud  <= '0;
              r_ra    <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_baud <= r_baud + 16'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_buf_ra  = r_ra;
  assign tx_buf_ren = r_ren;
  assign tx         = r_tx;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: a line receiver checks every frame cycle-by-cycle against
// the expected byte stream; the stimulus side checks completion timing, busy, reads, abort and reset.
module tb_uart_tx_stream;

  localparam int CPB   = 4;
  localparam int DL    = 9;
  localparam int DEPTH = 1 << DL;
`ifdef UART_TX_STREAM_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tx_start;
  logic [DL:0]   tx_len;
  logic          tx_abort;
  logic [DL-1:0] tx_buf_ra;
  logic          tx_buf_ren;
  logic [7:0]    tx_buf_rd;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  typedef struct {
    logic [7:0] data;
    longint     start;
  } frame_t;

  frame_t     sb[$];
  logic [7:0] mem [DEPTH];
  longint     cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         rx_flush = 1'b0;
  int         ren_count = 0;
  int         ra_err = 0;

  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_start   (tx_start),
    .tx_len     (tx_len),
    .tx_abort   (tx_abort),
    .tx_buf_ra  (tx_buf_ra),
    .tx_buf_ren (tx_buf_ren),
    .tx_buf_rd  (tx_buf_rd),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (tx_buf_ren) tx_buf_rd <= mem[tx_buf_ra];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Line value of bit k of a UART frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[3'(k - 1)];
`ifdef UART_TX_STREAM_PARITY_EN
    if (k == 9) return logic'(($countones(d) % 2) == 1);
`endif
    return 1'b1;
  endfunction

  task automatic monitor_loop();
    bit     active = 1'b0;
    frame_t cur;
    longint st = 0;
    int     bad = 0;
    int     k;
    forever begin
      @(negedge clk);
      if (rx_flush || reset_n !== 1'b1) begin
        active = 1'b0;
        continue;
      end
      if (tx_buf_ren === 1'b1) begin
        if (int'(tx_buf_ra) != ren_count) ra_err++;
        ren_count++;
      end
      if (!active && tx === 1'b0) begin
        check("frame_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          check("frame_start_cycle", 64'(cyc), 64'(cur.start));
          active = 1'b1;
          st     = cyc;
          bad    = 0;
        end
      end
      if (active) begin
        k = int'((cyc - st) / CPB);
        if (tx !== frame_bit(cur.data, k)) bad++;
        if (cyc - st == longint'(FRAME_CYC - 1)) begin
          check("frame_bits", 64'(bad), 64'(0));
          active = 1'b0;
        end
      end
    end
  endtask

  task automatic start_xfer(input int len, input int n, output longint t0);
    @(negedge clk);
    t0        = cyc;
    ren_count = 0;
    ra_err    = 0;
    for (int i = 0; i < n; i++)
      sb.push_back('{data: mem[i], start: t0 + 3 + longint'(i) * FRAME_CYC});
    tx_start = 1'b1;
    tx_len   = (DL + 1)'(len);
    @(negedge clk);
    tx_start = 1'b0;
    if (n > 0) check("ren_first_cycle", 64'(tx_buf_ren), 64'(1));
  endtask

  task automatic wait_done(input longint t0, input int n);
    longint exp_done = (n == 0) ? t0 + 1 : t0 + 3 + longint'(n) * FRAME_CYC;
    int     busy_bad = 0;
    bit     seen = 1'b0;
    for (int k = 0; k < n * FRAME_CYC + 20; k++) begin
      if (tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (n != 0 && tx_busy !== 1'b1) busy_bad++;
      @(negedge clk);
    end
    check("done_seen", 64'(seen), 64'(1));
    check("done_cycle", 64'(cyc), 64'(exp_done));
    check("busy_at_done", 64'(tx_busy), 64'(0));
    check("tx_idle_at_done", 64'(tx), 64'(1));
    check("busy_window", 64'(busy_bad), 64'(0));
    check("ren_count", 64'(ren_count), 64'(n));
    check("ra_sequence", 64'(ra_err), 64'(0));
    check("ra_zero_at_done", 64'(tx_buf_ra), 64'(0));
    check("frames_pending", 64'(sb.size()), 64'(0));
    @(negedge clk);
    check("done_one_cycle", 64'(tx_done), 64'(0));
  endtask

  task automatic run(input int len, input int n);
    longint t0;
    start_xfer(len, n, t0);
    wait_done(t0, n);
  endtask

  // Watch the line for a while after abort/reset: nothing may happen.
  task automatic expect_quiet(input string tag, input int cycles);
    int n_done = 0, n_busy = 0, n_ren = 0, n_low = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (tx_done !== 1'b0) n_done++;
      if (tx_busy !== 1'b0) n_busy++;
      if (tx_buf_ren !== 1'b0) n_ren++;
      if (tx !== 1'b1) n_low++;
    end
    check({tag, "_no_done"}, 64'(n_done), 64'(0));
    check({tag, "_no_busy"}, 64'(n_busy), 64'(0));
    check({tag, "_no_ren"}, 64'(n_ren), 64'(0));
    check({tag, "_line_high"}, 64'(n_low), 64'(0));
  endtask

  initial begin
    longint t0;
    longint target;
    int     n;
    reset_n  = 1'b0;
    tx_start = 1'b0;
    tx_abort = 1'b0;
    tx_len   = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    check("rst_tx", 64'(tx), 64'(1));
    check("rst_busy", 64'(tx_busy), 64'(0));
    check("rst_done", 64'(tx_done), 64'(0));
    check("rst_ren", 64'(tx_buf_ren), 64'(0));
    check("rst_ra", 64'(tx_buf_ra), 64'(0));
    reset_n = 1'b1;
    expect_quiet("post_reset", 5);

    mem[0] = 8'hA5;
    run(1, 1);

    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h55;
    run(3, 3);

    run(0, 0);

    mem[0] = 8'h07;
    run(1, 1);

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
      run(n, n);
    end

    // A second start while busy must not change the transfer.
    start_xfer(2, 2, t0);
    while (cyc < t0 + 50) @(negedge clk);
    tx_start = 1'b1;
    tx_len   = (DL + 1)'(4);
    @(negedge clk);
    tx_start = 1'b0;
    wait_done(t0, 2);

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    run(600, DEPTH);

    // Abort during data bit 3 of the third byte, together with a new start.
    start_xfer(5, 5, t0);
    target = t0 + 3 + 2 * FRAME_CYC + CPB + 3 * CPB + 1;
    while (cyc < target) @(negedge clk);
    check("busy_before_abort", 64'(tx_busy), 64'(1));
    tx_abort = 1'b1;
    tx_start = 1'b1;
    tx_len   = (DL + 1)'(3);
    rx_flush = 1'b1;
    @(negedge clk);
    tx_abort = 1'b0;
    tx_start = 1'b0;
    check("abort_tx", 64'(tx), 64'(1));
    check("abort_busy", 64'(tx_busy), 64'(0));
    check("abort_ren", 64'(tx_buf_ren), 64'(0));
    check("abort_ra", 64'(tx_buf_ra), 64'(0));
    sb.delete();
    expect_quiet("abort", 60);
    rx_flush = 1'b0;

    // Asynchronous reset inside a start bit.
    start_xfer(3, 3, t0);
    while (cyc < t0 + 3 + FRAME_CYC + 1) @(negedge clk);
    check("tx_low_before_reset", 64'(tx), 64'(0));
    rx_flush = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_tx", 64'(tx), 64'(1));
    check("async_rst_busy", 64'(tx_busy), 64'(0));
    check("async_rst_ra", 64'(tx_buf_ra), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    expect_quiet("reset", 60);
    rx_flush = 1'b0;

    for (int i = 0; i < 2; i++) mem[i] = 8'($urandom);
    run(2, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
